// File: rtl/instru_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// captures the returned instruction plus PC+4 into the IF/ID pipeline register.
module instru_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned SIZE_IM  = 128
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instru,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instru,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = XLEN + 1;
  // One bit wider than the PC so a SIZE_IM of 2^30 words cannot overflow the limit.
  localparam logic [AW-1:0] PC_LIMIT = AW'(SIZE_IM) << 2;

  typedef struct packed {
    logic [XLEN-1:0] instru;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{instru: '0, pc4: '0, valid: 1'b0};

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic            fault_q, fault_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_plus4;
  logic            out_of_range;

  // Redirect decode: branch wins over jump; low address bits are dropped.
  always_comb begin
    redirect       = branch_taken | jump;
    target_raw     = branch_taken ? branch_target : jump_target;
    target_aligned = {target_raw[XLEN-1:2], 2'b00};
    pc_plus4       = pc_q + XLEN'(4);
    out_of_range   = {1'b0, pc_q} >= PC_LIMIT;
  end

  // Next-state selection, first matching rule wins.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    fault_d = fault_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      pc_d    = target_aligned;
      if_id_d = BUBBLE;
      if (target_raw[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end else if (stall) begin
      pc_d    = pc_q;
    end else if (out_of_range) begin
      // Parked: only a redirect or reset moves the PC again.
      if_id_d = BUBBLE;
      fault_d = 1'b1;
    end else if (flush) begin
      if_id_d = BUBBLE;
      pc_d    = pc_plus4;
    end else begin
      if_id_d.instru = im_instru;
      if_id_d.pc4    = pc_plus4;
      if_id_d.valid  = 1'b1;
      pc_d           = pc_plus4;
      cnt_d          = cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= BUBBLE;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign im_addr      = pc_q;
  assign pc           = pc_q;
  assign if_id_instru = if_id_q.instru;
  assign if_id_pc4    = if_id_q.pc4;
  assign if_id_valid  = if_id_q.valid;
  assign fetch_fault  = fault_q;
  assign misalign     = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_instru_fetch.sv
// Bench for instru_fetch: two instances (128-word and 4-word memories) driven by the
// same directed and random stimulus, checked every cycle against a behavioural model.
module tb_instru_fetch;

  localparam logic [31:0] VA = 32'h1111_0001;
  localparam logic [31:0] VB = 32'h2222_0002;
  localparam logic [31:0] VC = 32'h3333_0003;
  localparam logic [31:0] VD = 32'h4444_0004;
  localparam logic [31:0] V8 = 32'h8888_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;

  logic [31:0] mem [128];
  logic [31:0] o_addr [2];
  logic [31:0] im_in  [2];
  logic [31:0] o_pc   [2];
  logic [31:0] o_ins  [2];
  logic [31:0] o_pc4  [2];
  logic        o_val  [2];
  logic        o_flt  [2];
  logic        o_mis  [2];
  logic [31:0] o_cnt  [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign im_in[0] = (o_addr[0] < 32'd512) ? mem[o_addr[0][8:2]] : 32'hBAD0_BAD0;
  assign im_in[1] = (o_addr[1] < 32'd512) ? mem[o_addr[1][8:2]] : 32'hBAD0_BAD0;

  instru_fetch #(.RESET_PC(32'h0), .SIZE_IM(128)) dut_a (
    .clk(clk), .rst(rst), .im_addr(o_addr[0]), .im_instru(im_in[0]),
    .stall(stall), .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .pc(o_pc[0]), .if_id_instru(o_ins[0]),
    .if_id_pc4(o_pc4[0]), .if_id_valid(o_val[0]), .fetch_fault(o_flt[0]),
    .misalign(o_mis[0]), .fetch_count(o_cnt[0]));

  instru_fetch #(.RESET_PC(32'h0), .SIZE_IM(4)) dut_b (
    .clk(clk), .rst(rst), .im_addr(o_addr[1]), .im_instru(im_in[1]),
    .stall(stall), .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .pc(o_pc[1]), .if_id_instru(o_ins[1]),
    .if_id_pc4(o_pc4[1]), .if_id_valid(o_val[1]), .fetch_fault(o_flt[1]),
    .misalign(o_mis[1]), .fetch_count(o_cnt[1]));

  // Behavioural model state, one slot per instance.
  longint      m_size [2] = '{128, 4};
  logic [31:0] m_pc  [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_pc4 [2];
  logic [31:0] m_cnt [2];
  logic        m_val [2];
  logic        m_flt [2];
  logic        m_mis [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] t;
      if (rst) begin
        m_pc[k] = 32'h0; m_ins[k] = '0; m_pc4[k] = '0; m_val[k] = 1'b0;
        m_flt[k] = 1'b0; m_mis[k] = 1'b0; m_cnt[k] = '0;
      end else if (branch_taken || jump) begin
        t = branch_taken ? branch_target : jump_target;
        if (t % 4 != 0) m_mis[k] = 1'b1;
        m_pc[k] = t - (t % 4);
        m_ins[k] = '0; m_pc4[k] = '0; m_val[k] = 1'b0;
      end else if (stall) begin
        m_pc[k] = m_pc[k];
      end else if (longint'(m_pc[k]) >= 4 * m_size[k]) begin
        m_flt[k] = 1'b1;
        m_ins[k] = '0; m_pc4[k] = '0; m_val[k] = 1'b0;
      end else if (flush) begin
        m_ins[k] = '0; m_pc4[k] = '0; m_val[k] = 1'b0;
        m_pc[k] = m_pc[k] + 32'd4;
      end else begin
        m_ins[k] = mem[m_pc[k] / 4];
        m_pc4[k] = m_pc[k] + 32'd4;
        m_val[k] = 1'b1;
        m_pc[k] = m_pc[k] + 32'd4;
        m_cnt[k] = m_cnt[k] + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, ".pc"},      o_pc[k],   m_pc[k]);
        chk({p, ".im_addr"}, o_addr[k], m_pc[k]);
        chk({p, ".instru"},  o_ins[k],  m_ins[k]);
        chk({p, ".pc4"},     o_pc4[k],  m_pc4[k]);
        chk({p, ".valid"},   32'(o_val[k]), 32'(m_val[k]));
        chk({p, ".fault"},   32'(o_flt[k]), 32'(m_flt[k]));
        chk({p, ".misalign"},32'(o_mis[k]), 32'(m_mis[k]));
        chk({p, ".count"},   o_cnt[k],  m_cnt[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  function automatic logic [31:0] pick_tgt();
    logic [31:0] t;
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 7)      t = 32'h1F0 + 32'($urandom_range(0, 8)) * 4;
    else if (r == 8) t = $urandom;
    else             t = 32'($urandom_range(0, 24)) * 4;
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = VA; mem[1] = VB; mem[2] = VC; mem[3] = VD; mem[8] = V8;

    // Reset and straight-line fetch
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    chk("t1.rst_pc", o_pc[0], 32'h0);
    chk("t1.rst_valid", 32'(o_val[0]), 32'h0);
    chk("t1.rst_count", o_cnt[0], 32'h0);
    idle();
    step();
    chk("t1.pc4", o_pc[0], 32'h4);
    chk("t1.instA", o_ins[0], VA);
    step();
    chk("t1.pc8", o_pc[0], 32'h8);
    chk("t1.instB", o_ins[0], VB);
    chk("t1.pc4B", o_pc4[0], 32'h8);

    // Stall holds PC and IF/ID
    stall = 1'b1;
    step(); step();
    chk("t2.pc_hold", o_pc[0], 32'h8);
    chk("t2.inst_hold", o_ins[0], VB);
    chk("t2.pc4_hold", o_pc4[0], 32'h8);
    chk("t2.count_hold", o_cnt[0], 32'd2);
    stall = 1'b0;
    step();
    chk("t2.instC", o_ins[0], VC);
    chk("t2.pc4C", o_pc4[0], 32'hC);
    chk("t2.count", o_cnt[0], 32'd3);

    // Branch overrides stall
    branch_taken = 1'b1; branch_target = 32'h20; stall = 1'b1;
    step();
    chk("t3.pc", o_pc[0], 32'h20);
    chk("t3.bubble", 32'(o_val[0]), 32'h0);
    idle();
    step();
    chk("t3.inst8", o_ins[0], V8);
    chk("t3.pc4", o_pc4[0], 32'h24);

    // Branch beats jump; misaligned jump rounds down and sets sticky flag
    branch_taken = 1'b1; branch_target = 32'h10; jump = 1'b1; jump_target = 32'h42;
    step();
    chk("t4.prio", o_pc[0], 32'h10);
    chk("t4.mis0", 32'(o_mis[0]), 32'h0);
    branch_taken = 1'b0;
    step();
    chk("t4.pc40", o_pc[0], 32'h40);
    chk("t4.mis1", 32'(o_mis[0]), 32'h1);
    idle();
    step();
    chk("t4.mis_sticky", 32'(o_mis[0]), 32'h1);

    // Range fault on the 4-word instance
    rst = 1'b1;
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("t5.pc16", o_pc[1], 32'h10);
    chk("t5.instD", o_ins[1], VD);
    chk("t5.nofault", 32'(o_flt[1]), 32'h0);
    step();
    chk("t5.fault", 32'(o_flt[1]), 32'h1);
    chk("t5.park", o_pc[1], 32'h10);
    chk("t5.bubble", 32'(o_val[1]), 32'h0);
    step();
    chk("t5.park2", o_pc[1], 32'h10);
    jump = 1'b1; jump_target = 32'h0;
    step();
    jump = 1'b0;
    step();
    chk("t5.resume", o_ins[1], VA);
    chk("t5.fault_sticky", 32'(o_flt[1]), 32'h1);

    // Flush then mid-sequence reset
    flush = 1'b1;
    step();
    chk("t6.flush_bubble", 32'(o_val[0]), 32'h0);
    chk("t6.flush_pc", o_pc[0], 32'h8);
    flush = 1'b0; jump = 1'b1; jump_target = 32'h3; rst = 1'b1;
    step();
    chk("t6.rst_pc", o_pc[0], 32'h0);
    chk("t6.rst_count", o_cnt[0], 32'h0);
    chk("t6.rst_mis", 32'(o_mis[0]), 32'h0);
    chk("t6.rst_fault", 32'(o_flt[1]), 32'h0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      jump         = ($urandom_range(0, 11) == 0);
      branch_target = pick_tgt();
      jump_target   = pick_tgt();
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
